// File: rtl/adder_pkg.sv
// Shared adder-side definitions: default operand width, tdata packing offsets
// and pointer-width derivation.
package adder_pkg;

    localparam int ADDER_WIDTH = 4;
    localparam int D1_OFFSET   = 0;

    // data2 sits directly above data1 in the packed beat
    function automatic int d2_offset(input int width);
        return width;
    endfunction

    function automatic int ptr_width(input int entries);
        return (entries > 1) ? $clog2(entries) : 1;
    endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock FIFO for packed operand pairs; head entry is visible on data_o
// whenever the FIFO is non-empty.
module axis_sync_fifo
    import adder_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] data_i,
    output logic [DW-1:0] data_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int AW = ptr_width(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push_s, do_pop_s;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign do_push_s = push_i & ~full_o;
    assign do_pop_s  = pop_i & ~empty_o;
    assign data_o    = mem_q[rd_ptr_q];

    // Next-state for pointers and occupancy; DEPTH is a power of two so the
    // pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers and storage array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= data_i;
            end
        end
    end

endmodule

// File: rtl/axis_operand_tx.sv
// Operand-pair buffer feeding an AXI-Stream adder input with sticky overflow.
// Define AXIS_OPERAND_TX_TLAST_EN to generate tlast every PKT_LEN beats.
module axis_operand_tx
    import adder_pkg::*;
#(
    parameter int WIDTH   = ADDER_WIDTH,
    parameter int DEPTH   = 4,
    parameter int PKT_LEN = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_i,
    input  logic [WIDTH-1:0]   data1_i,
    input  logic [WIDTH-1:0]   data2_i,
    output logic               ready_o,
    output logic               overflow_o,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic [2*WIDTH-1:0] m_axis_tdata,
    output logic               m_axis_tlast
);

    localparam int DW     = 2 * WIDTH;
    localparam int D2_OFF = d2_offset(WIDTH);

    logic [DW-1:0] pair_s;
    logic          full_s, empty_s, push_s;
    logic          run_q, overflow_q;

    assign pair_s[D1_OFFSET +: WIDTH] = data1_i;
    assign pair_s[D2_OFF +: WIDTH]    = data2_i;

    // run_q keeps ready low for the whole reset and raises it on the first edge after
    assign ready_o       = run_q & ~full_s;
    assign push_s        = valid_i & ready_o;
    assign m_axis_tvalid = ~empty_s;
    assign overflow_o    = overflow_q;

    axis_sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (push_s),
        .pop_i   (m_axis_tready),
        .data_i  (pair_s),
        .data_o  (m_axis_tdata),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    // Ready enable and sticky overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q      <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (valid_i && !ready_o) begin
                overflow_q <= 1'b1;
            end else begin
                overflow_q <= overflow_q;
            end
        end
    end

`ifdef AXIS_OPERAND_TX_TLAST_EN
    localparam int CW = ptr_width(PKT_LEN);

    logic [CW-1:0] beat_cnt_q, beat_cnt_d;
    logic          beat_s;

    assign beat_s       = m_axis_tvalid & m_axis_tready;
    assign m_axis_tlast = m_axis_tvalid & (beat_cnt_q == CW'(PKT_LEN - 1));

    // Beat counter wraps after the last beat of a packet.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (beat_s) begin
            if (beat_cnt_q == CW'(PKT_LEN - 1)) begin
                beat_cnt_d = '0;
            end else begin
                beat_cnt_d = beat_cnt_q + CW'(1);
            end
        end else begin
            beat_cnt_d = beat_cnt_q;
        end
    end

    // Beat counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end
`else
    assign m_axis_tlast = 1'b0;
`endif

endmodule

// File: tb/tb_axis_operand_tx.sv
// Self-checking bench for axis_operand_tx: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_axis_operand_tx;

    localparam int W       = 4;
    localparam int DEPTH   = 4;
    localparam int PKT_LEN = 8;
`ifdef AXIS_OPERAND_TX_TLAST_EN
    localparam bit TLAST_EN = 1'b1;
`else
    localparam bit TLAST_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           valid_i = 1'b0;
    logic [W-1:0]   data1_i = '0;
    logic [W-1:0]   data2_i = '0;
    logic           ready_o, overflow_o;
    logic           m_axis_tvalid, m_axis_tlast;
    logic           m_axis_tready = 1'b0;
    logic [2*W-1:0] m_axis_tdata;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: buffered pairs in order, sticky overflow, ready-enable
    logic [2*W-1:0] pair_q[$];
    bit             m_ovf;
    bit             m_run;

    always #5 clk = ~clk;

    axis_operand_tx #(.WIDTH(W), .DEPTH(DEPTH), .PKT_LEN(PKT_LEN)) dut (
        .clk           (clk),
        .reset         (reset),
        .valid_i       (valid_i),
        .data1_i       (data1_i),
        .data2_i       (data2_i),
        .ready_o       (ready_o),
        .overflow_o    (overflow_o),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast)
    );

    // Advance one clock: update the model from the current inputs, then step the DUT.
    task automatic cycle();
        bit rdy;
        bit do_push;
        bit do_pop;
        rdy     = m_run && (pair_q.size() < DEPTH);
        do_push = valid_i && rdy;
        do_pop  = (pair_q.size() != 0) && m_axis_tready;
        if (do_pop) void'(pair_q.pop_front());
        if (do_push) pair_q.push_back({data2_i, data1_i});
        if (valid_i && !rdy) m_ovf = 1'b1;
        m_run = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input int d1, input int d2);
        valid_i = v;
        data1_i = W'(d1);
        data2_i = W'(d2);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 0, 0);
        m_axis_tready = 1'b0;
        pair_q.delete();
        m_ovf = 1'b0;
        m_run = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        cycle();
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 0, 0);
        m_axis_tready = 1'b1;
        pair_q.delete();
        m_ovf = 1'b0;
        m_run = 1'b0;
        @(negedge clk);
        n_checks++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_tvalid got=%b exp=0", m_axis_tvalid); end
        n_checks++; if (m_axis_tlast !== 1'b0) begin n_fail++; $display("FAIL rst_tlast got=%b exp=0", m_axis_tlast); end
        n_checks++; if (m_axis_tdata !== 8'h00) begin n_fail++; $display("FAIL rst_tdata got=%h exp=00", m_axis_tdata); end
        n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL rst_overflow got=%b exp=0", overflow_o); end
        n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_ready got=%b exp=0", ready_o); end
        reset = 1'b1;
        cycle();
        n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ready_after got=%b exp=1", ready_o); end
        n_checks++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_tready_ignored got=%b exp=0", m_axis_tvalid); end
    endtask

    task automatic test_single();
        do_reset();
        m_axis_tready = 1'b1;
        drive(1'b1, 3, 5);
        cycle();
        drive(1'b0, 0, 0);
        n_checks++; if (m_axis_tvalid !== 1'b1) begin n_fail++; $display("FAIL single_tvalid got=%b exp=1", m_axis_tvalid); end
        n_checks++; if (m_axis_tdata !== 8'h53) begin n_fail++; $display("FAIL single_tdata got=%h exp=53", m_axis_tdata); end
        cycle();
        n_checks++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL single_tvalid_off got=%b exp=0", m_axis_tvalid); end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_beats [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_reset();
        m_axis_tready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, i, i);
            cycle();
            n_checks++; if (m_axis_tdata !== 8'h11) begin n_fail++; $display("FAIL bp_hold_%0d got=%h exp=11", i, m_axis_tdata); end
        end
        drive(1'b0, 0, 0);
        n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready got=%b exp=0", ready_o); end
        m_axis_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_beats[i]) begin
                n_fail++; $display("FAIL bp_beat_%0d got=%b/%h exp=1/%h", i, m_axis_tvalid, m_axis_tdata, exp_beats[i]);
            end
            cycle();
        end
        n_checks++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL bp_drained got=%b exp=0", m_axis_tvalid); end
    endtask

    task automatic test_overflow();
        int guard;
        do_reset();
        m_axis_tready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, int'($urandom_range(0, 6)), int'($urandom_range(0, 6)));
            cycle();
        end
        drive(1'b1, 7, 7);
        cycle();
        drive(1'b0, 0, 0);
        n_checks++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_set got=%b exp=1", overflow_o); end
        m_axis_tready = 1'b1;
        guard = 0;
        while (pair_q.size() != 0 && guard < 10) begin
            n_checks++; if (m_axis_tdata === 8'h77 || m_axis_tdata !== pair_q[0]) begin
                n_fail++; $display("FAIL ovf_drain got=%h exp=%h", m_axis_tdata, pair_q[0]);
            end
            cycle();
            guard++;
        end
        n_checks++; if (m_axis_tvalid !== 1'b0 || overflow_o !== 1'b1) begin
            n_fail++; $display("FAIL ovf_sticky got tvalid=%b ovf=%b exp 0/1", m_axis_tvalid, overflow_o);
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] exp_order [4] = '{8'h22, 8'h33, 8'h44, 8'h55};
        do_reset();
        m_axis_tready = 1'b0;
        drive(1'b1, 1, 1); cycle();
        drive(1'b1, 2, 2); cycle();
        m_axis_tready = 1'b1;
        drive(1'b1, 3, 3); cycle();
        m_axis_tready = 1'b0;
        drive(1'b0, 0, 0);
        n_checks++; if (ready_o !== 1'b1 || m_axis_tdata !== 8'h22) begin
            n_fail++; $display("FAIL simul_head got=%b/%h exp=1/22", ready_o, m_axis_tdata);
        end
        drive(1'b1, 4, 4); cycle();
        n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL simul_occ3 got=%b exp=1", ready_o); end
        drive(1'b1, 5, 5); cycle();
        drive(1'b0, 0, 0);
        n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL simul_occ4 got=%b exp=0", ready_o); end
        m_axis_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (m_axis_tdata !== exp_order[i]) begin
                n_fail++; $display("FAIL simul_order_%0d got=%h exp=%h", i, m_axis_tdata, exp_order[i]);
            end
            cycle();
        end
    endtask

    task automatic test_random_tlast();
        int beats = 0;
        int cyc = 0;
        bit exp_last;
        do_reset();
        while (beats < 17 && cyc < 600) begin
            drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            m_axis_tready = 1'($urandom_range(0, 1));
            #1;
            n_checks++; if (m_axis_tvalid !== (pair_q.size() != 0) || ready_o !== (pair_q.size() < DEPTH)) begin
                n_fail++; $display("FAIL rnd_flags got=%b/%b exp=%b/%b", m_axis_tvalid, ready_o, pair_q.size() != 0, pair_q.size() < DEPTH);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                beats++;
                exp_last = TLAST_EN && (beats % PKT_LEN == 0);
                n_checks++; if (m_axis_tlast !== exp_last || m_axis_tdata !== pair_q[0]) begin
                    n_fail++; $display("FAIL rnd_beat_%0d got=%b/%h exp=%b/%h", beats, m_axis_tlast, m_axis_tdata, exp_last, pair_q[0]);
                end
            end else if (m_axis_tvalid) begin
                n_checks++; if (m_axis_tdata !== pair_q[0]) begin
                    n_fail++; $display("FAIL rnd_hold got=%h exp=%h", m_axis_tdata, pair_q[0]);
                end
            end
            cycle();
            cyc++;
        end
        n_checks++; if (beats != 17) begin n_fail++; $display("FAIL rnd_timeout got=%0d exp=17", beats); end
        drive(1'b0, 0, 0);
    endtask

    task automatic test_reset_mid();
        int beats = 0;
        bit exp_last;
        do_reset();
        m_axis_tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, i, i + 1);
            cycle();
        end
        drive(1'b0, 0, 0);
        cycle();
        m_axis_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 9, i);
            cycle();
        end
        drive(1'b1, 1, 1);
        cycle();
        drive(1'b1, 2, 2);
        cycle();
        drive(1'b0, 0, 0);
        reset = 1'b0;
        pair_q.delete();
        m_ovf = 1'b0;
        m_run = 1'b0;
        #2;
        n_checks++; if (m_axis_tvalid !== 1'b0 || overflow_o !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset got=%b/%b exp=0/0", m_axis_tvalid, overflow_o);
        end
        @(negedge clk);
        reset = 1'b1;
        cycle();
        m_axis_tready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive(i < 8, i, 15 - i);
            if (m_axis_tvalid) begin
                beats++;
                exp_last = TLAST_EN && (beats == 8);
                n_checks++; if (m_axis_tlast !== exp_last) begin
                    n_fail++; $display("FAIL mid_tlast_%0d got=%b exp=%b", beats, m_axis_tlast, exp_last);
                end
            end
            cycle();
        end
        n_checks++; if (beats != 8) begin n_fail++; $display("FAIL mid_beats got=%0d exp=8", beats); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_simultaneous();
        test_random_tlast();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
